// File: rtl/decoder_rr_arbiter.sv
// decoder_rr_arbiter: round-robin owner of the shared 2-to-4 decoder select path.
// Define ARB_TIMEOUT_EN to force release after HOLD_MAX grant cycles.
module decoder_rr_arbiter #(
    parameter int HOLD_MAX = 16,
    parameter int GAP_CYC  = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic       done,
    output logic [1:0] sel,
    output logic [3:0] grant,
    output logic       busy,
    output logic       timeout
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_e;

    localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC + 1) : 1;

    state_e        state_q, state_d;
    logic [1:0]    sel_q, sel_d;
    logic [1:0]    ptr_q, ptr_d;
    logic [3:0]    grant_q, grant_d;
    logic [GW-1:0] gap_q, gap_d;

    logic          pick_vld;
    logic [1:0]    pick_idx;
    logic          rel_norm;
    logic          rel_force;

    // Scan from the farthest offset down so the nearest request to ptr wins.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = ptr_q;
        for (int i = 3; i >= 0; i--) begin
            if (req[ptr_q + 2'(i)]) begin
                pick_vld = 1'b1;
                pick_idx = ptr_q + 2'(i);
            end
        end
    end

    assign rel_norm = (state_q == GRANT) && (done || !req[sel_q]);

`ifdef ARB_TIMEOUT_EN
    localparam int HW = (HOLD_MAX > 1) ? $clog2(HOLD_MAX + 1) : 1;

    logic [HW-1:0] hold_q, hold_d;
    logic          timeout_q, timeout_d;

    // A normal release in the expiry cycle wins, so no pulse then.
    assign rel_force = (state_q == GRANT) && !rel_norm
                    && (hold_q == HW'(HOLD_MAX));

    always_comb begin
        hold_d    = hold_q;
        timeout_d = rel_force;
        if (state_q == IDLE && pick_vld) begin
            hold_d = HW'(1);
        end else if (state_q == GRANT && !rel_norm && !rel_force) begin
            hold_d = hold_q + HW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            hold_q    <= hold_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    assign rel_force = 1'b0;
    assign timeout   = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        gap_d   = gap_q;
        unique case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    state_d = GRANT;
                    sel_d   = pick_idx;
                    grant_d = 4'b0001 << pick_idx;
                end
            end
            GRANT: begin
                if (rel_norm || rel_force) begin
                    grant_d = 4'b0000;
                    ptr_d   = sel_q + 2'd1;
                    gap_d   = GW'(1);
                    state_d = (GAP_CYC == 0) ? IDLE : GAP;
                end
            end
            GAP: begin
                if (gap_q >= GW'(GAP_CYC)) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = 4'b0000;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sel_q   <= 2'd0;
            ptr_q   <= 2'd0;
            grant_q <= 4'b0000;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            gap_q   <= gap_d;
        end
    end

    assign sel   = sel_q;
    assign grant = grant_q;
    assign busy  = (state_q != IDLE);

    a_onehot: assert property (
        @(posedge clk) disable iff (!rst_n) $onehot0(grant_q));

    a_sel_match: assert property (
        @(posedge clk) disable iff (!rst_n)
        (grant_q != 4'b0000) |-> (grant_q == (4'b0001 << sel_q)));

endmodule

// File: tb/tb_decoder_rr_arbiter.sv
// Testbench for decoder_rr_arbiter: table vectors, corner sequences, random vs model.
// Expectations follow ARB_TIMEOUT_EN when it is defined for the build.
module tb_decoder_rr_arbiter;

    localparam int HOLD = 4;
    localparam int GAP  = 1;
`ifdef ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = 4'b0000;
    logic       done = 1'b0;
    logic [1:0] sel;
    logic [3:0] grant;
    logic       busy;
    logic       timeout;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    decoder_rr_arbiter #(
        .HOLD_MAX(HOLD),
        .GAP_CYC (GAP)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req),
        .done   (done),
        .sel    (sel),
        .grant  (grant),
        .busy   (busy),
        .timeout(timeout)
    );

    typedef struct {
        logic [3:0] req;
        logic       done;
        logic [3:0] g;
        logic [1:0] s;
        logic       b;
    } vec_t;

    vec_t tbl[24];

    // Reference: who owns the path, how long, and how many dead cycles remain.
    int m_owner;
    int m_sel;
    int m_ptr;
    int m_gap;
    int m_held;
    bit m_to;

    task automatic m_reset();
        m_owner = -1;
        m_sel   = 0;
        m_ptr   = 0;
        m_gap   = 0;
        m_held  = 0;
        m_to    = 1'b0;
    endtask

    task automatic m_release();
        m_ptr   = (m_owner + 1) % 4;
        m_owner = -1;
        m_gap   = GAP;
    endtask

    task automatic m_step(input logic [3:0] r, input logic d);
        m_to = 1'b0;
        if (m_owner >= 0) begin
            m_held++;
            if (d || !r[m_owner]) begin
                m_release();
            end else if (TO_EN && m_held >= HOLD) begin
                m_release();
                m_to = 1'b1;
            end
        end else if (m_gap > 0) begin
            m_gap--;
        end else if (r != 4'b0000) begin
            for (int k = 3; k >= 0; k--) begin
                if (r[(m_ptr + k) % 4]) m_owner = (m_ptr + k) % 4;
            end
            m_sel  = m_owner;
            m_held = 0;
        end
    endtask

    function automatic logic [7:0] m_out();
        logic [3:0] g;
        g = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
        return {g, 2'(m_sel), (m_owner >= 0) || (m_gap > 0), m_to};
    endfunction

    task automatic check(input string name, input logic [7:0] exp);
        logic [7:0] got;
        got = {grant, sel, busy, timeout};
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s t=%0t: got grant/sel/busy/to=%b_%b_%b_%b want %b_%b_%b_%b",
                     name, $time, got[7:4], got[3:2], got[1], got[0],
                     exp[7:4], exp[3:2], exp[1], exp[0]);
        end
    endtask

    task automatic tick();
        m_step(req, done);
        @(posedge clk);
        #1;
    endtask

    task automatic tick_chk(input string name);
        tick();
        check(name, m_out());
    endtask

    task automatic async_reset(input string name);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check(name, 8'h00);
        m_reset();
        @(posedge clk);
        #1;
        check({name, "_held"}, 8'h00);
        req   = 4'b0000;
        done  = 1'b0;
        rst_n = 1'b1;
    endtask

    initial begin
        tbl[0]  = '{4'b0001, 1'b0, 4'b0001, 2'd0, 1'b1};
        tbl[1]  = '{4'b0001, 1'b1, 4'b0000, 2'd0, 1'b1};
        tbl[2]  = '{4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0};
        tbl[3]  = '{4'b1111, 1'b0, 4'b0010, 2'd1, 1'b1};
        tbl[4]  = '{4'b1111, 1'b1, 4'b0000, 2'd1, 1'b1};
        tbl[5]  = '{4'b1111, 1'b0, 4'b0000, 2'd1, 1'b0};
        tbl[6]  = '{4'b1111, 1'b0, 4'b0100, 2'd2, 1'b1};
        tbl[7]  = '{4'b1111, 1'b1, 4'b0000, 2'd2, 1'b1};
        tbl[8]  = '{4'b0101, 1'b0, 4'b0000, 2'd2, 1'b0};
        tbl[9]  = '{4'b0101, 1'b0, 4'b0001, 2'd0, 1'b1};
        tbl[10] = '{4'b0101, 1'b1, 4'b0000, 2'd0, 1'b1};
        tbl[11] = '{4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0};
        tbl[12] = '{4'b0010, 1'b0, 4'b0010, 2'd1, 1'b1};
        tbl[13] = '{4'b0000, 1'b0, 4'b0000, 2'd1, 1'b1};
        tbl[14] = '{4'b0000, 1'b0, 4'b0000, 2'd1, 1'b0};
        tbl[15] = '{4'b1111, 1'b0, 4'b0100, 2'd2, 1'b1};
        tbl[16] = '{4'b1111, 1'b1, 4'b0000, 2'd2, 1'b1};
        tbl[17] = '{4'b1111, 1'b0, 4'b0000, 2'd2, 1'b0};
        tbl[18] = '{4'b1111, 1'b0, 4'b1000, 2'd3, 1'b1};
        tbl[19] = '{4'b1111, 1'b1, 4'b0000, 2'd3, 1'b1};
        tbl[20] = '{4'b1111, 1'b0, 4'b0000, 2'd3, 1'b0};
        tbl[21] = '{4'b1111, 1'b0, 4'b0001, 2'd0, 1'b1};
        tbl[22] = '{4'b1111, 1'b1, 4'b0000, 2'd0, 1'b1};
        tbl[23] = '{4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0};

        m_reset();
        #2;
        check("reset_state", 8'h00);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < 24; i++) begin
            req  = tbl[i].req;
            done = tbl[i].done;
            tick();
            check($sformatf("vec%0d", i),
                  {tbl[i].g, tbl[i].s, tbl[i].b, 1'b0});
        end
        req  = 4'b0000;
        done = 1'b0;

        req = 4'b0001;
        tick();
        check("pre_reset_grant", {4'b0001, 2'd0, 1'b1, 1'b0});
        async_reset("reset_mid_grant");

        req = 4'b0010;
        if (TO_EN) begin
            for (int k = 0; k < HOLD; k++) begin
                tick();
                check("to_hold", {4'b0010, 2'd1, 1'b1, 1'b0});
            end
            tick();
            check("to_pulse", {4'b0000, 2'd1, 1'b1, 1'b1});
            tick();
            check("to_after", {4'b0000, 2'd1, 1'b0, 1'b0});
            req = 4'b0000;
            tick();
            check("to_idle", {4'b0000, 2'd1, 1'b0, 1'b0});
        end else begin
            for (int k = 0; k < 120; k++) begin
                tick();
                check("no_to_hold", {4'b0010, 2'd1, 1'b1, 1'b0});
            end
            req = 4'b0000;
            tick();
            check("no_to_drop", {4'b0000, 2'd1, 1'b1, 1'b0});
            tick();
            check("no_to_idle", {4'b0000, 2'd1, 1'b0, 1'b0});
        end

        for (int c = 0; c < 3000; c++) begin
            if (c == 1500) async_reset("reset_random");
            if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
            done = ($urandom_range(0, 3) == 0);
            tick_chk("random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
